// File: rtl/updown_counter_debounced.sv
// Two-button up/down counter: each raw button is synchronised, debounced and edge-detected
// into a single count event; the counter supports load, a programmable ceiling/step, and wrap or saturate.
module updown_counter_debounced #(
    parameter int WIDTH           = 3,
    parameter int MAX_COUNT       = 2**WIDTH - 1,
    parameter int STEP            = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WRAP_MODE       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_up,
    input  logic             push_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             limit_hit
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Arithmetic runs one bit wider so overflow past MAX_COUNT is visible.
    localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   RANGE_W = (WIDTH+1)'(MAX_COUNT + 1);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX_COUNT);

    logic [1:0] raw;
    logic [1:0] evt;

    assign raw = {push_down, push_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_prev_reg;
            logic [CNT_W-1:0] stable_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg      <= 1'b0;
                    sync2_reg      <= 1'b0;
                    deb_reg        <= 1'b0;
                    deb_prev_reg   <= 1'b0;
                    stable_cnt_reg <= '0;
                end else begin
                    sync1_reg    <= raw[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    // Any return to the current debounced level restarts the stability count.
                    if (sync2_reg == deb_reg) begin
                        stable_cnt_reg <= '0;
                    end else if (stable_cnt_reg == CNT_LAST) begin
                        deb_reg        <= sync2_reg;
                        stable_cnt_reg <= '0;
                    end else begin
                        stable_cnt_reg <= stable_cnt_reg + 1'b1;
                    end
                end
            end

            assign evt[gi] = deb_reg & ~deb_prev_reg;
        end
    endgenerate

    logic [WIDTH-1:0] count_reg, count_next;
    logic             limit_reg, limit_next;
    logic [WIDTH:0]   wide;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   wrap_val;

    always_comb begin
        count_next = count_reg;
        limit_next = 1'b0;
        wide       = {1'b0, count_reg};
        up_sum     = wide + STEP_W;
        wrap_val   = '0;
        if (load) begin
            count_next = ({1'b0, load_value} > MAX_W) ? MAX_N : load_value;
        end else if (evt[0] && evt[1]) begin
            count_next = count_reg;
        end else if (evt[0]) begin
            if (up_sum <= MAX_W) begin
                count_next = up_sum[WIDTH-1:0];
            end else begin
                limit_next = 1'b1;
                if (WRAP_MODE != 0) begin
                    wrap_val   = up_sum - RANGE_W;
                    count_next = wrap_val[WIDTH-1:0];
                end else begin
                    count_next = MAX_N;
                end
            end
        end else if (evt[1]) begin
            if (wide >= STEP_W) begin
                wrap_val   = wide - STEP_W;
                count_next = wrap_val[WIDTH-1:0];
            end else begin
                limit_next = 1'b1;
                if (WRAP_MODE != 0) begin
                    wrap_val   = wide + RANGE_W - STEP_W;
                    count_next = wrap_val[WIDTH-1:0];
                end else begin
                    count_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            limit_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            limit_reg <= limit_next;
        end
    end

    assign count     = count_reg;
    assign limit_hit = limit_reg;
    assign at_max    = (count_reg == MAX_N);
    assign at_min    = (count_reg == '0);

endmodule

// File: tb/tb_updown_counter_debounced.sv
// Directed bench: default counter (A), saturating step-3 ceiling-6 counter (B), ceiling-5 counter (C).
module tb_updown_counter_debounced;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       pu_a = 0, pd_a = 0, ld_a = 0;
    logic [2:0] lv_a = 0, cnt_a;
    logic       amax_a, amin_a, lim_a;

    logic       pu_b = 0, pd_b = 0, ld_b = 0;
    logic [2:0] lv_b = 0, cnt_b;
    logic       amax_b, amin_b, lim_b;

    logic       pu_c = 0, pd_c = 0, ld_c = 0;
    logic [2:0] lv_c = 0, cnt_c;
    logic       amax_c, amin_c, lim_c;

    int checks = 0;
    int failures = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    always #5 clk = ~clk;

    updown_counter_debounced dut_a (
        .clk(clk), .rst_n(rst_n), .push_up(pu_a), .push_down(pd_a),
        .load(ld_a), .load_value(lv_a), .count(cnt_a),
        .at_max(amax_a), .at_min(amin_a), .limit_hit(lim_a)
    );

    updown_counter_debounced #(
        .WIDTH(3), .MAX_COUNT(6), .STEP(3), .DEBOUNCE_CYCLES(4), .WRAP_MODE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .push_up(pu_b), .push_down(pd_b),
        .load(ld_b), .load_value(lv_b), .count(cnt_b),
        .at_max(amax_b), .at_min(amin_b), .limit_hit(lim_b)
    );

    updown_counter_debounced #(
        .WIDTH(3), .MAX_COUNT(5), .STEP(1), .DEBOUNCE_CYCLES(4), .WRAP_MODE(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .push_up(pu_c), .push_down(pd_c),
        .load(ld_c), .load_value(lv_c), .count(cnt_c),
        .at_max(amax_c), .at_min(amin_c), .limit_hit(lim_c)
    );

    // Cycles with limit_hit high; a stuck or stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        pulses_a <= pulses_a + int'(lim_a);
        pulses_b <= pulses_b + int'(lim_b);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) $display("check %s observed=%0d expected=%0d ok", tag, obs, exp);
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press_a(input logic up, input logic dn, input int hold);
        @(negedge clk);
        pu_a = up;
        pd_a = dn;
        repeat (hold) @(negedge clk);
        pu_a = 1'b0;
        pd_a = 1'b0;
        repeat (10) @(negedge clk);
        $display("press A up=%0b down=%0b -> count=%0d", up, dn, cnt_a);
    endtask

    task automatic press_b(input logic up, input logic dn);
        @(negedge clk);
        pu_b = up;
        pd_b = dn;
        repeat (10) @(negedge clk);
        pu_b = 1'b0;
        pd_b = 1'b0;
        repeat (10) @(negedge clk);
        $display("press B up=%0b down=%0b -> count=%0d", up, dn, cnt_b);
    endtask

    task automatic load_a(input logic [2:0] v);
        @(negedge clk);
        ld_a = 1'b1;
        lv_a = v;
        @(negedge clk);
        ld_a = 1'b0;
        $display("load A %0d -> count=%0d", v, cnt_a);
    endtask

    task automatic load_b(input logic [2:0] v);
        @(negedge clk);
        ld_b = 1'b1;
        lv_b = v;
        @(negedge clk);
        ld_b = 1'b0;
        $display("load B %0d -> count=%0d", v, cnt_b);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_count", int'(cnt_a), 0);
        check("rst_at_min", int'(amin_a), 1);
        check("rst_at_max", int'(amax_a), 0);
        check("rst_limit", int'(lim_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: exact latency of the first press, then two more presses
        @(negedge clk);
        pu_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("lat_k+5_unchanged", int'(cnt_a), 0);
        @(posedge clk);
        #1;
        check("lat_k+6_updated", int'(cnt_a), 1);
        check("lat_limit_low", int'(lim_a), 0);
        repeat (3) @(negedge clk);
        pu_a = 1'b0;
        repeat (10) @(negedge clk);
        press_a(1'b1, 1'b0, 10);
        check("up_press2", int'(cnt_a), 2);
        press_a(1'b1, 1'b0, 10);
        check("up_press3", int'(cnt_a), 3);
        check("t1_no_limit", pulses_a, 0);

        // Test 2: bouncing button gives a single increment
        load_a(3'd0);
        check("load0", int'(cnt_a), 0);
        for (int r = 0; r < 4; r++) begin
            pu_a = 1'b1;
            repeat (3) @(negedge clk);
            pu_a = 1'b0;
            @(negedge clk);
        end
        check("bounce_rejected", int'(cnt_a), 0);
        press_a(1'b1, 1'b0, 10);
        check("bounce_one_inc", int'(cnt_a), 1);
        check("t2_no_limit", pulses_a, 0);

        // Test 3: wrap at both bounds
        load_a(3'd7);
        check("load7", int'(cnt_a), 7);
        check("load7_at_max", int'(amax_a), 1);
        press_a(1'b1, 1'b0, 10);
        check("wrap_up", int'(cnt_a), 0);
        check("wrap_up_at_min", int'(amin_a), 1);
        check("wrap_up_pulse", pulses_a, 1);
        press_a(1'b0, 1'b1, 10);
        check("wrap_down", int'(cnt_a), 7);
        check("wrap_down_pulse", pulses_a, 2);

        // Test 5: simultaneous presses and load priority
        press_a(1'b1, 1'b1, 10);
        check("simul_hold", int'(cnt_a), 7);
        check("simul_no_pulse", pulses_a, 2);
        load_a(3'd2);
        @(negedge clk);
        pu_a = 1'b1;
        repeat (6) @(negedge clk);
        ld_a = 1'b1;
        lv_a = 3'd7;
        @(negedge clk);
        ld_a = 1'b0;
        check("load_beats_event", int'(cnt_a), 7);
        repeat (4) @(negedge clk);
        pu_a = 1'b0;
        repeat (10) @(negedge clk);
        check("load_event_count", int'(cnt_a), 7);
        check("load_event_no_pulse", pulses_a, 2);

        @(negedge clk);
        ld_c = 1'b1;
        lv_c = 3'd7;
        @(negedge clk);
        ld_c = 1'b0;
        $display("load C 7 -> count=%0d", cnt_c);
        check("clamp_load", int'(cnt_c), 5);
        check("clamp_at_max", int'(amax_c), 1);

        // Test 4: saturate mode with step 3, ceiling 6
        load_b(3'd5);
        check("sat_load5", int'(cnt_b), 5);
        press_b(1'b1, 1'b0);
        check("sat_up_clip", int'(cnt_b), 6);
        check("sat_up_at_max", int'(amax_b), 1);
        check("sat_up_pulse", pulses_b, 1);
        press_b(1'b1, 1'b0);
        check("sat_up_again", int'(cnt_b), 6);
        check("sat_up_again_pulse", pulses_b, 2);
        load_b(3'd1);
        press_b(1'b0, 1'b1);
        check("sat_down_clip", int'(cnt_b), 0);
        check("sat_down_pulse", pulses_b, 3);

        // Test 6: reset in the middle of a down debounce
        @(negedge clk);
        pd_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_count", int'(cnt_a), 0);
        check("midrst_at_min", int'(amin_a), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_not_yet", int'(cnt_a), 0);
        repeat (6) @(negedge clk);
        check("midrst_one_down", int'(cnt_a), 7);
        repeat (10) @(negedge clk);
        pd_a = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_repeat", int'(cnt_a), 7);
        check("midrst_pulse", pulses_a, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
